// File: rtl/trigger_defs.sv
// Shared definitions for the trigger controller and its register interface:
// FSM state encodings, acquisition mode and edge-select codes.
package trigger_defs;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRETRIG   = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POSTTRIG  = 3'd3,
      ST_DONE      = 3'd4,
      ST_HOLDOFF   = 3'd5
   } trig_state_t;

   // Acquisition modes; code 3 behaves like single
   localparam logic [1:0] MODE_NORMAL = 2'd0;
   localparam logic [1:0] MODE_AUTO   = 2'd1;
   localparam logic [1:0] MODE_SINGLE = 2'd2;

   // Edge selection; code 3 behaves like rising
   localparam logic [1:0] EDGE_RISE   = 2'd0;
   localparam logic [1:0] EDGE_FALL   = 2'd1;
   localparam logic [1:0] EDGE_EITHER = 2'd2;

   // True when the timeout counter may fire a trigger on its own
   function automatic logic is_auto_mode(input logic [1:0] m);
      return (m == MODE_AUTO);
   endfunction

endpackage

// File: rtl/trig_edge_detect.sv
// Comparator edge qualifier: remembers the previous comparator level,
// suppresses edges inside the dead zone and applies the edge selection.
module trig_edge_detect
   import trigger_defs::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       cmp_q,
   input  logic       cmp_z,
   input  logic [1:0] edge_sel,
   output logic       hit
);

   logic q_prev;
   logic rise;
   logic fall;
   logic want_rise;
   logic want_fall;

   // Track the comparator level of the previous cycle in every state
   always_ff @(posedge clk) begin
      if (!rstn) begin
         q_prev <= 1'b0;
      end else begin
         q_prev <= cmp_q;
      end
   end

   // Qualify edges outside the dead zone and match them against the selection
   always_comb begin
      rise      = 1'b0;
      fall      = 1'b0;
      want_rise = 1'b0;
      want_fall = 1'b0;
      if (!cmp_z) begin
         rise = !q_prev & cmp_q;
         fall = q_prev & !cmp_q;
      end else begin
         rise = 1'b0;
         fall = 1'b0;
      end
      case (edge_sel)
         EDGE_RISE: begin
            want_rise = 1'b1;
            want_fall = 1'b0;
         end
         EDGE_FALL: begin
            want_rise = 1'b0;
            want_fall = 1'b1;
         end
         EDGE_EITHER: begin
            want_rise = 1'b1;
            want_fall = 1'b1;
         end
         default: begin
            want_rise = 1'b1;
            want_fall = 1'b0;
         end
      endcase
      hit = (rise & want_rise) | (fall & want_fall);
   end

endmodule

// File: rtl/trigger_ctrl.sv
// Trigger controller: sequences a capture buffer through pre-trigger fill,
// trigger wait, post-trigger fill, a one-cycle done and an optional holdoff.
// All outputs are registered and change together with the state.
module trigger_ctrl
   import trigger_defs::*;
#(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              clkIn,
   input  logic              rstnIn,
   input  logic              start,
   input  logic              stop,
   input  logic              force_trig,
   input  logic [1:0]        mode,
   input  logic [1:0]        edge_sel,
   input  logic [ADDR_W-1:0] pre_len,
   input  logic [ADDR_W-1:0] post_len,
   input  logic [CNT_W-1:0]  holdoff,
   input  logic [CNT_W-1:0]  auto_timeout,
   input  logic              cmp_q,
   input  logic              cmp_z,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] trig_addr,
   output logic              triggered,
   output logic              done,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] A_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] A_INC  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   A_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  C_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  C_INC  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W:0]    C_ONE  = {{CNT_W{1'b0}}, 1'b1};

   trig_state_t       state;

   // Settings captured on every entry to PRETRIG
   logic [1:0]        mode_l;
   logic [1:0]        edge_l;
   logic [ADDR_W-1:0] pre_l;
   logic [ADDR_W-1:0] post_l;
   logic [CNT_W-1:0]  hold_l;
   logic [CNT_W-1:0]  tout_l;

   logic [ADDR_W-1:0] pre_cnt;
   logic [ADDR_W-1:0] post_cnt;
   logic [CNT_W-1:0]  hold_cnt;
   logic [CNT_W-1:0]  tout_cnt;

   logic              edge_hit;
   logic              pre_last;
   logic              post_last;
   logic              hold_last;
   logic              auto_hit;
   logic              trig_event;
   logic              pre_entry;

   trig_edge_detect u_edge (
      .clk      (clkIn),
      .rstn     (rstnIn),
      .cmp_q    (cmp_q),
      .cmp_z    (cmp_z),
      .edge_sel (edge_l),
      .hit      (edge_hit)
   );

   // Per-cycle decisions from the counters and latched settings;
   // counters hold the number of completed cycles, so compare against count+1
   always_comb begin
      pre_last   = (({1'b0, pre_cnt} + A_ONE) == {1'b0, pre_l});
      post_last  = (({1'b0, post_cnt} + A_ONE) == {1'b0, post_l});
      hold_last  = (({1'b0, hold_cnt} + C_ONE) >= {1'b0, hold_l});
      auto_hit   = is_auto_mode(mode_l) && (tout_l != C_ZERO) &&
                   (({1'b0, tout_cnt} + C_ONE) == {1'b0, tout_l});
      trig_event = 1'b0;
      pre_entry  = 1'b0;
      if (state == ST_WAIT_TRIG) begin
         trig_event = edge_hit | force_trig | auto_hit;
      end else begin
         trig_event = 1'b0;
      end
      if (stop) begin
         pre_entry = 1'b0;
      end else if (state == ST_IDLE) begin
         pre_entry = start;
      end else if (state == ST_HOLDOFF) begin
         pre_entry = hold_last;
      end else begin
         pre_entry = 1'b0;
      end
   end

   // Acquisition FSM with counters and registered status outputs
   always_ff @(posedge clkIn) begin
      if (!rstnIn) begin
         state     <= ST_IDLE;
         wr_en     <= 1'b0;
         wr_addr   <= A_ZERO;
         trig_addr <= A_ZERO;
         triggered <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         pre_cnt   <= A_ZERO;
         post_cnt  <= A_ZERO;
         hold_cnt  <= C_ZERO;
         tout_cnt  <= C_ZERO;
         mode_l    <= MODE_NORMAL;
         edge_l    <= EDGE_RISE;
         pre_l     <= A_ZERO;
         post_l    <= A_ZERO;
         hold_l    <= C_ZERO;
         tout_l    <= C_ZERO;
      end else if (stop) begin
         state     <= ST_IDLE;
         wr_en     <= 1'b0;
         triggered <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else if (pre_entry) begin
         // New acquisition: fresh settings, buffer restarts at address 0
         state     <= ST_PRETRIG;
         busy      <= 1'b1;
         triggered <= 1'b0;
         done      <= 1'b0;
         wr_addr   <= A_ZERO;
         wr_en     <= (pre_len != A_ZERO);
         pre_cnt   <= A_ZERO;
         mode_l    <= mode;
         edge_l    <= edge_sel;
         pre_l     <= pre_len;
         post_l    <= post_len;
         hold_l    <= holdoff;
         tout_l    <= auto_timeout;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               wr_en <= 1'b0;
               busy  <= 1'b0;
            end
            ST_PRETRIG: begin
               wr_en <= 1'b1;
               if (pre_l == A_ZERO) begin
                  // Nothing was written this cycle, so the address stays
                  state    <= ST_WAIT_TRIG;
                  tout_cnt <= C_ZERO;
               end else if (pre_last) begin
                  wr_addr  <= wr_addr + A_INC;
                  state    <= ST_WAIT_TRIG;
                  tout_cnt <= C_ZERO;
               end else begin
                  wr_addr <= wr_addr + A_INC;
                  pre_cnt <= pre_cnt + A_INC;
               end
            end
            ST_WAIT_TRIG: begin
               wr_addr <= wr_addr + A_INC;
               if (trig_event) begin
                  trig_addr <= wr_addr;
                  triggered <= 1'b1;
                  post_cnt  <= A_ZERO;
                  if (post_l == A_ZERO) begin
                     state <= ST_DONE;
                     wr_en <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_POSTTRIG;
                     wr_en <= 1'b1;
                  end
               end else begin
                  tout_cnt <= tout_cnt + C_INC;
                  wr_en    <= 1'b1;
               end
            end
            ST_POSTTRIG: begin
               wr_addr <= wr_addr + A_INC;
               if (post_last) begin
                  state <= ST_DONE;
                  wr_en <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  post_cnt <= post_cnt + A_INC;
                  wr_en    <= 1'b1;
               end
            end
            ST_DONE: begin
               wr_en    <= 1'b0;
               hold_cnt <= C_ZERO;
               case (mode_l)
                  MODE_NORMAL, MODE_AUTO: begin
                     state <= ST_HOLDOFF;
                  end
                  MODE_SINGLE: begin
                     state     <= ST_IDLE;
                     triggered <= 1'b0;
                     busy      <= 1'b0;
                  end
                  default: begin
                     state     <= ST_IDLE;
                     triggered <= 1'b0;
                     busy      <= 1'b0;
                  end
               endcase
            end
            ST_HOLDOFF: begin
               wr_en    <= 1'b0;
               hold_cnt <= hold_cnt + C_INC;
            end
            default: begin
               state     <= ST_IDLE;
               wr_en     <= 1'b0;
               triggered <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
